// File: rtl/xc_io_pkg.sv
// ----------------------------------------------------------------------------
// xc_io_pkg
//   Shared definitions for the header I/O conditioner:
//     - clog2()          : ceiling log2, never less than 1 (safe as a width)
//     - SCAN_INTERNAL /
//       SCAN_STROBE      : values of the scan_mode input
//     - scan_state_t     : scanner state encoding
//     - scan_dbg_t       : scanner debug view (state plus the mode it runs in)
// ----------------------------------------------------------------------------
package xc_io_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam logic SCAN_INTERNAL = 1'b0;
    localparam logic SCAN_STROBE   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    typedef struct packed {
        scan_state_t state;
        logic        mode;
    } scan_dbg_t;

endpackage

// File: rtl/xc_deglitch.sv
// ----------------------------------------------------------------------------
// xc_deglitch
//   One asynchronous input: a SYNC_STAGES-deep synchroniser followed by a
//   persistence filter. The filtered level only moves once the synchronised
//   sample has disagreed with it for FILTER_LEN consecutive cycles, so pulses
//   of FILTER_LEN-1 cycles or less never reach the output.
//   Ports:
//     sysclk  - system clock
//     reset   - asynchronous active-high reset
//     din     - raw asynchronous input
//     level   - filtered level (registered)
//     changed - one-cycle pulse in the cycle level updates (registered)
// ----------------------------------------------------------------------------
module xc_deglitch
    import xc_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic sysclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic changed
);

    localparam int                CNT_W   = clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            changed <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            changed <= 1'b0;
            if (sample == level) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_MAX) begin
                // This is the FILTER_LEN-th consecutive disagreeing sample.
                level   <= sample;
                cnt_q   <= '0;
                changed <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/xc_header_io.sv
// ----------------------------------------------------------------------------
// xc_header_io
//   Board-edge conditioner between the header pins and the main logic.
//   Every correlator line and the strobe pin are synchronised and deglitched;
//   a one-hot scanner walks MUX_LINES selects, stepping either from an
//   internal divider or from filtered strobe rising edges.
//   Ports:
//     sysclk      - system clock
//     reset       - asynchronous active-high reset
//     enable      - scanner run enable
//     scan_mode   - 0: internal divider, 1: strobe-driven
//     scan_div    - internal-mode advance period minus one, in cycles
//     line_in     - raw asynchronous header inputs
//     strobe      - raw asynchronous strobe pin
//     line_clean  - synchronised, deglitched line levels
//     line_edge   - one-cycle pulse on any line_clean change
//     strobe_rise - one-cycle pulse on filtered strobe rising edge
//     mux_out     - one-hot select, all zero while idle
//     mux_index   - current select index
//     scan_wrap   - one-cycle pulse when the index wraps to 0
//
//   Handshake note: there is no valid/ready traffic here; every output is a
//   level or a single-cycle pulse qualified only by the clock.
// ----------------------------------------------------------------------------
module xc_header_io
    import xc_io_pkg::*;
#(
    parameter int NUM_LINES   = 4,
    parameter int MUX_LINES   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        scan_mode,
    input  logic [DIV_WIDTH-1:0]        scan_div,
    input  logic [NUM_LINES-1:0]        line_in,
    input  logic                        strobe,
    output logic [NUM_LINES-1:0]        line_clean,
    output logic [NUM_LINES-1:0]        line_edge,
    output logic                        strobe_rise,
    output logic [MUX_LINES-1:0]        mux_out,
    output logic [clog2(MUX_LINES)-1:0] mux_index,
    output logic                        scan_wrap
);

    localparam int              IDX_W    = clog2(MUX_LINES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MUX_LINES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic strobe_level;
    logic strobe_changed;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        xc_deglitch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_line (
            .sysclk  (sysclk),
            .reset   (reset),
            .din     (line_in[i]),
            .level   (line_clean[i]),
            .changed (line_edge[i])
        );
    end

    xc_deglitch #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_strobe (
        .sysclk  (sysclk),
        .reset   (reset),
        .din     (strobe),
        .level   (strobe_level),
        .changed (strobe_changed)
    );

    // Both terms are flops, so this stays a registered-output pulse.
    assign strobe_rise = strobe_changed & strobe_level;

    // ------------------------------------------------------------------
    // Scanner
    // ------------------------------------------------------------------
    scan_state_t          state_q, state_d;
    logic                 mode_q;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [IDX_W-1:0]     idx_d;
    logic [MUX_LINES-1:0] mux_d;
    logic                 wrap_d;
    logic                 advance;
    scan_dbg_t            scan_dbg;

    assign scan_dbg = '{state: state_q, mode: mode_q};

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= SCAN_INTERNAL;
            div_q     <= '0;
            mux_index <= '0;
            mux_out   <= '0;
            scan_wrap <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= scan_mode;
            div_q     <= div_d;
            mux_index <= idx_d;
            mux_out   <= mux_d;
            scan_wrap <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = mux_index;
        mux_d   = mux_out;
        wrap_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                mux_d = '0;
                div_d = '0;
                if (enable) begin
                    // Entry cycle shows the held index; stepping starts next cycle.
                    state_d = RUN;
                    mux_d   = MUX_LINES'(1) << mux_index;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    mux_d   = '0;
                    div_d   = '0;
                end else if (scan_mode != mode_q) begin
                    // A mode switch restarts the divider; the new mode rules
                    // from the following cycle.
                    div_d = '0;
                end else if (mode_q == SCAN_INTERNAL) begin
                    // >= so a period shrunk below the running count fires
                    // immediately instead of wrapping the counter.
                    if (div_q >= scan_div) begin
                        div_d   = '0;
                        advance = 1'b1;
                    end else begin
                        div_d = div_q + DIV_WIDTH'(1);
                    end
                end else begin
                    div_d   = '0;
                    advance = strobe_rise;
                end
            end
            default: begin
                state_d = IDLE;
                mux_d   = '0;
                div_d   = '0;
            end
        endcase

        if (advance) begin
            if (mux_index == IDX_LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = mux_index + IDX_W'(1);
            end
            mux_d = MUX_LINES'(1) << idx_d;
        end
    end

endmodule

// File: tb/tb_xc_header_io.sv
// ----------------------------------------------------------------------------
// tb_xc_header_io
//   Directed bench for xc_header_io: a default build (16 selects) and a
//   5-select build sharing clock, reset and pins.
// ----------------------------------------------------------------------------
module tb_xc_header_io;

    logic        sysclk;
    logic        reset;
    logic        enable;
    logic        scan_mode;
    logic [15:0] scan_div;
    logic [3:0]  line_in;
    logic        strobe;
    logic [3:0]  line_clean;
    logic [3:0]  line_edge;
    logic        strobe_rise;
    logic [15:0] mux_out;
    logic [3:0]  mux_index;
    logic        scan_wrap;

    logic        enable5;
    logic [3:0]  line_clean5;
    logic [3:0]  line_edge5;
    logic        strobe_rise5;
    logic [4:0]  mux_out5;
    logic [2:0]  mux_index5;
    logic        scan_wrap5;

    int n_tests;
    int n_fail;

    xc_header_io dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .enable      (enable),
        .scan_mode   (scan_mode),
        .scan_div    (scan_div),
        .line_in     (line_in),
        .strobe      (strobe),
        .line_clean  (line_clean),
        .line_edge   (line_edge),
        .strobe_rise (strobe_rise),
        .mux_out     (mux_out),
        .mux_index   (mux_index),
        .scan_wrap   (scan_wrap)
    );

    xc_header_io #(.MUX_LINES(5)) dut5 (
        .sysclk      (sysclk),
        .reset       (reset),
        .enable      (enable5),
        .scan_mode   (1'b0),
        .scan_div    (16'd0),
        .line_in     (line_in),
        .strobe      (strobe),
        .line_clean  (line_clean5),
        .line_edge   (line_edge5),
        .strobe_rise (strobe_rise5),
        .mux_out     (mux_out5),
        .mux_index   (mux_index5),
        .scan_wrap   (scan_wrap5)
    );

    // clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs driven and outputs sampled 1 time unit later
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // n clean strobe pulses (8 high, 8 low), counting rises and watching mux_out
    task automatic strobe_pulses(input int n, output int rises, output logic mux_seen);
        rises    = 0;
        mux_seen = 1'b0;
        for (int p = 0; p < n; p++) begin
            for (int h = 0; h < 16; h++) begin
                strobe = (h < 8);
                tick(1);
                if (strobe_rise) rises++;
                if (mux_out != 16'd0) mux_seen = 1'b1;
            end
        end
        strobe = 1'b0;
    endtask

    int   rises;
    logic mux_seen;
    int   exp_idx;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        enable5   = 1'b0;
        scan_mode = 1'b0;
        scan_div  = 16'd0;
        line_in   = 4'b0000;
        strobe    = 1'b0;

        // ---- reset state ----
        #1;
        check("rst_line_clean", 32'(line_clean), 32'h0);
        check("rst_line_edge",  32'(line_edge),  32'h0);
        check("rst_mux_out",    32'(mux_out),    32'h0);
        check("rst_mux_index",  32'(mux_index),  32'h0);
        check("rst_wrap_rise",  32'({scan_wrap, strobe_rise}), 32'h0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // ---- latency: 0101 appears after SYNC_STAGES+FILTER_LEN = 6 cycles ----
        line_in = 4'b0101;
        tick(5);
        check("lat_clean_at5", 32'(line_clean), 32'h0);
        tick(1);
        check("lat_clean_at6", 32'(line_clean), 32'h5);
        check("lat_edge_at6",  32'(line_edge),  32'h5);
        tick(1);
        check("lat_edge_at7",  32'(line_edge),  32'h0);
        tick(2);

        // ---- 3-cycle glitch rejected ----
        line_in = 4'b0111;
        tick(3);
        line_in = 4'b0101;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            check("glitch3_clean", 32'(line_clean), 32'h5);
            check("glitch3_edge",  32'(line_edge),  32'h0);
        end

        // ---- 4-cycle pulse passes; falls 6 cycles after the input falls ----
        line_in = 4'b0111;
        tick(4);
        line_in = 4'b0101;
        tick(1);
        check("pulse4_pre", 32'(line_clean), 32'h5);
        tick(1);
        check("pulse4_rise_clean", 32'(line_clean), 32'h7);
        check("pulse4_rise_edge",  32'(line_edge),  32'h2);
        tick(3);
        check("pulse4_hold", 32'(line_clean), 32'h7);
        tick(1);
        check("pulse4_fall_clean", 32'(line_clean), 32'h5);
        check("pulse4_fall_edge",  32'(line_edge),  32'h2);
        tick(2);

        // ---- internal mode, scan_div=2: one step every 3 cycles ----
        scan_div = 16'd2;
        enable   = 1'b1;
        tick(1);
        check("int_entry_mux", 32'(mux_out),   32'h1);
        check("int_entry_idx", 32'(mux_index), 32'h0);
        tick(2);
        check("int_no_step_yet", 32'(mux_index), 32'h0);
        tick(1);
        check("int_step1_idx", 32'(mux_index), 32'h1);
        check("int_step1_mux", 32'(mux_out),   32'h2);
        for (int k = 2; k <= 16; k++) begin
            tick(3);
            exp_idx = k % 16;
            check("int_idx",  32'(mux_index), 32'(exp_idx));
            check("int_mux",  32'(mux_out),   32'(1) << exp_idx);
            check("int_wrap", 32'(scan_wrap), (k == 16) ? 32'h1 : 32'h0);
        end
        tick(1);
        check("int_wrap_one_cycle", 32'(scan_wrap), 32'h0);
        enable = 1'b0;
        tick(1);
        check("int_disable_mux", 32'(mux_out),   32'h0);
        check("int_disable_idx", 32'(mux_index), 32'h0);
        tick(2);

        // ---- strobe mode: 5 pulses -> index 5, divider held at 0 ----
        scan_mode = 1'b1;
        enable    = 1'b1;
        tick(1);
        check("str_entry_mux", 32'(mux_out), 32'h1);
        strobe_pulses(5, rises, mux_seen);
        check("str_rises", 32'(rises), 32'd5);
        check("str_idx",   32'(mux_index), 32'd5);
        check("str_mux",   32'(mux_out), 32'h20);
        check("str_div",   32'(dut.div_q), 32'h0);

        // ---- strobe while idle: pulses still seen, no advance ----
        enable = 1'b0;
        tick(1);
        strobe_pulses(3, rises, mux_seen);
        check("idle_rises",    32'(rises), 32'd3);
        check("idle_idx",      32'(mux_index), 32'd5);
        check("idle_mux_seen", 32'(mux_seen), 32'h0);

        // ---- 5-select build, scan_div=0: 0,1,2,3,4,0,1 ----
        enable5 = 1'b1;
        tick(1);
        check("m5_entry_idx", 32'(mux_index5), 32'h0);
        check("m5_entry_mux", 32'(mux_out5),   32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_idx = k % 5;
            check("m5_idx",  32'(mux_index5), 32'(exp_idx));
            check("m5_mux",  32'(mux_out5),   32'(1) << exp_idx);
            check("m5_wrap", 32'(scan_wrap5), (k == 5) ? 32'h1 : 32'h0);
        end
        enable5 = 1'b0;
        tick(1);
        check("m5_disable_mux", 32'(mux_out5), 32'h0);

        // ---- reset mid-scan at index 7 with line_clean=1111 ----
        scan_mode = 1'b0;
        scan_div  = 16'd0;
        line_in   = 4'b1111;
        tick(8);
        check("mid_clean_pre", 32'(line_clean), 32'hF);
        enable = 1'b1;
        tick(3);
        check("mid_idx_pre", 32'(mux_index), 32'd7);
        check("mid_mux_pre", 32'(mux_out),   32'h80);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_clean", 32'(line_clean), 32'h0);
        check("mid_rst_mux",   32'(mux_out),    32'h0);
        check("mid_rst_idx",   32'(mux_index),  32'h0);
        check("mid_rst_misc",  32'({scan_wrap, strobe_rise, line_edge}), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("post_idx", 32'(mux_index), 32'h0);
        check("post_mux", 32'(mux_out),   32'h1);
        tick(4);
        check("post_clean_at5", 32'(line_clean), 32'h0);
        tick(1);
        check("post_clean_at6", 32'(line_clean), 32'hF);
        check("post_edge_at6",  32'(line_edge),  32'hF);
        enable = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
